// File: rtl/mc_input_req_fifo.sv
// System request buffer feeding the memory-controller decoder: first-word-fall-through
// FIFO with early busy back-pressure. Optional stored parity check: MC_INFIFO_PARITY_EN.
module mc_input_req_fifo #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 64,
   parameter int DEPTH       = 8,
   parameter int BUSY_MARGIN = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sys__mc__dram_req,
   input  logic                     sys__mc__dram_rdwr,
   input  logic [ADDR_W-1:0]        sys__mc__dram_addr,
   input  logic [DATA_W-1:0]        sys__mc__dram_wr_data,
   input  logic                     input_fifo_read,
   output logic                     input_fifo_read_rdwr,
   output logic [ADDR_W-1:0]        input_fifo_read_addr,
   output logic [DATA_W-1:0]        input_fifo_read_wr_data,
   output logic                     input_fifo_empty,
   output logic                     mc__sys__dram_busy,
   output logic [$clog2(DEPTH):0]   input_fifo_count,
   output logic                     input_fifo_overflow,
   output logic                     input_fifo_underflow,
   output logic                     input_fifo_parity_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] BUSY_CNT = CW'(DEPTH - BUSY_MARGIN);

   function automatic logic even_par(input logic rdwr,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [DATA_W-1:0] data);
      return ^{rdwr, addr, data};
   endfunction

   logic              rdwr_mem [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PW-1:0] wp, rp;
   logic [CW-1:0] count, count_nxt;
   logic          push, pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
   always_comb begin
      pop       = input_fifo_read && (count != '0);
      push      = sys__mc__dram_req && ((count != FULL_CNT) || pop);
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp                   <= '0;
         rp                   <= '0;
         count                <= '0;
         mc__sys__dram_busy   <= 1'b0;
         input_fifo_overflow  <= 1'b0;
         input_fifo_underflow <= 1'b0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop)  rp <= rp + PW'(1);
         count              <= count_nxt;
         mc__sys__dram_busy <= (count_nxt >= BUSY_CNT);
         if (sys__mc__dram_req && !push)
            input_fifo_overflow <= 1'b1;
         if (input_fifo_read && (count == '0))
            input_fifo_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rdwr_mem[i] <= 1'b0;
            addr_mem[i] <= '0;
            data_mem[i] <= '0;
         end
      end else if (push) begin
         rdwr_mem[wp] <= sys__mc__dram_rdwr;
         addr_mem[wp] <= sys__mc__dram_addr;
         data_mem[wp] <= sys__mc__dram_wr_data;
      end
   end

   assign input_fifo_read_rdwr    = rdwr_mem[rp];
   assign input_fifo_read_addr    = addr_mem[rp];
   assign input_fifo_read_wr_data = data_mem[rp];
   assign input_fifo_empty        = (count == '0);
   assign input_fifo_count        = count;

`ifdef MC_INFIFO_PARITY_EN
   logic par_mem [DEPTH];
   logic par_err;

   // Parity is recomputed from the head outputs so the check covers the read mux too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
         par_err <= 1'b0;
      end else begin
         if (push)
            par_mem[wp] <= even_par(sys__mc__dram_rdwr, sys__mc__dram_addr,
                                    sys__mc__dram_wr_data);
         if (pop && (par_mem[rp] != even_par(input_fifo_read_rdwr, input_fifo_read_addr,
                                             input_fifo_read_wr_data)))
            par_err <= 1'b1;
      end
   end

   assign input_fifo_parity_err = par_err;
`else
   assign input_fifo_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mc_input_req_fifo.sv
// Randomized self-checking bench for mc_input_req_fifo against a queue-based model.
module tb_mc_input_req_fifo;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int DEPTH = 8;
   localparam int BUSY_MARGIN = 2;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic              rdwr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req = 1'b0, rdwr = 1'b0, rd = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic              h_rdwr, empty, busy, ovf, unf, perr;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_data;
   logic [CW-1:0]     cnt;

   mc_input_req_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .BUSY_MARGIN(BUSY_MARGIN)) dut (
      .clk(clk), .reset(reset),
      .sys__mc__dram_req(req), .sys__mc__dram_rdwr(rdwr),
      .sys__mc__dram_addr(addr), .sys__mc__dram_wr_data(wdata),
      .input_fifo_read(rd),
      .input_fifo_read_rdwr(h_rdwr), .input_fifo_read_addr(h_addr),
      .input_fifo_read_wr_data(h_data),
      .input_fifo_empty(empty), .mc__sys__dram_busy(busy),
      .input_fifo_count(cnt), .input_fifo_overflow(ovf),
      .input_fifo_underflow(unf), .input_fifo_parity_err(perr)
   );

   always #5 clk = ~clk;

   ent_t q[$];
   logic m_over, m_under, m_busy;
   int   n_chk = 0, n_pass = 0;

   // Drive one cycle of stimulus, clock it, advance the model, sample 1 ns after the edge.
   task automatic step(input logic r, input logic rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic p);
      bit do_pop, do_push;
      @(negedge clk);
      req = r; rdwr = rw; addr = a; wdata = d; rd = p;
      @(posedge clk);
      do_pop  = p && (q.size() > 0);
      do_push = r && ((q.size() < DEPTH) || do_pop);
      if (p && q.size() == 0) m_under = 1'b1;
      if (r && !do_push)      m_over  = 1'b1;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{rdwr: rw, addr: a, data: d});
      m_busy = (q.size() >= DEPTH - BUSY_MARGIN);
      #1;
      req = 1'b0; rd = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req = 1'b0; rd = 1'b0;
      reset = 1'b0;
      #2 reset = 1'b1;
      q.delete();
      m_over = 1'b0; m_under = 1'b0; m_busy = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if ({empty, busy, cnt, ovf, unf, perr} !== {1'b1, 1'b0, CW'(0), 3'b000})
         $display("FAIL reset_ctrl got e=%b b=%b c=%0d o=%b u=%b p=%b", empty, busy, cnt, ovf, unf, perr);
      else n_pass++;
      n_chk++; if ({h_rdwr, h_addr, h_data} !== '0)
         $display("FAIL reset_head got %b %h %h expected zeros", h_rdwr, h_addr, h_data);
      else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      step(1'b1, 1'b0, 32'h0000_1234, 64'hA5A5, 1'b0);
      n_chk++; if ({empty, cnt} !== {1'b0, CW'(1)})
         $display("FAIL single_push got empty=%b count=%0d expected 0/1", empty, cnt);
      else n_pass++;
      n_chk++; if ({h_rdwr, h_addr, h_data} !== {1'b0, 32'h0000_1234, 64'hA5A5})
         $display("FAIL single_head got %b %h %h expected 0 00001234 a5a5", h_rdwr, h_addr, h_data);
      else n_pass++;
      step(1'b0, 1'b0, '0, '0, 1'b1);
      n_chk++; if ({empty, cnt} !== {1'b1, CW'(0)})
         $display("FAIL single_pop got empty=%b count=%0d expected 1/0", empty, cnt);
      else n_pass++;
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, i[0], ADDR_W'(32'h100 + i), DATA_W'(i * 3), 1'b0);
         n_chk++; if (busy !== (i >= DEPTH - BUSY_MARGIN))
            $display("FAIL fill_busy push %0d got %b expected %b", i, busy, (i >= DEPTH - BUSY_MARGIN));
         else n_pass++;
      end
      step(1'b1, 1'b1, 32'hDEAD, 64'hBEEF, 1'b0);
      n_chk++; if ({ovf, cnt} !== {1'b1, CW'(DEPTH)})
         $display("FAIL overflow got ovf=%b count=%0d expected 1/%0d", ovf, cnt, DEPTH);
      else n_pass++;
      for (int i = 1; i <= DEPTH; i++) begin
         n_chk++; if (h_addr !== ADDR_W'(32'h100 + i))
            $display("FAIL drain_order entry %0d got %h expected %h", i, h_addr, 32'h100 + i);
         else n_pass++;
         step(1'b0, 1'b0, '0, '0, 1'b1);
         n_chk++; if (busy !== ((DEPTH - i) >= DEPTH - BUSY_MARGIN))
            $display("FAIL drain_busy count %0d got %b", DEPTH - i, busy);
         else n_pass++;
      end
   endtask

   task automatic test_simul();
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ADDR_W'(i), DATA_W'(i), 1'b0);
      step(1'b1, 1'b1, 32'h33, 64'h33, 1'b1);
      n_chk++; if (cnt !== CW'(3))
         $display("FAIL simul_cnt3 got %0d expected 3", cnt);
      else n_pass++;
      while (q.size() < DEPTH) step(1'b1, 1'b0, ADDR_W'(32'h40 + q.size()), DATA_W'(q.size()), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, i[1], ADDR_W'(32'h500 + i), DATA_W'($urandom), 1'b1);
         n_chk++; if ({cnt, ovf} !== {CW'(DEPTH), 1'b0} || {h_rdwr, h_addr, h_data} !== q[0])
            $display("FAIL simul_full cyc %0d got c=%0d o=%b head %h expected %h", i, cnt, ovf,
                     {h_rdwr, h_addr, h_data}, q[0]);
         else n_pass++;
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b0, 1'b0, '0, '0, 1'b1);
      n_chk++; if ({unf, cnt, empty} !== {1'b1, CW'(0), 1'b1})
         $display("FAIL underflow got u=%b c=%0d e=%b expected 1/0/1", unf, cnt, empty);
      else n_pass++;
      step(1'b1, 1'b1, 32'hCAFE_0001, 64'h1111_2222, 1'b0);
      n_chk++; if ({h_rdwr, h_addr, h_data} !== {1'b1, 32'hCAFE_0001, 64'h1111_2222} || cnt !== CW'(1))
         $display("FAIL underflow_push got %b %h %h c=%0d", h_rdwr, h_addr, h_data, cnt);
      else n_pass++;
      step(1'b1, 1'b0, 32'h77, 64'h77, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1);
      step(1'b1, 1'b0, 32'h88, 64'h88, 1'b1);
      n_chk++; if ({cnt, h_addr} !== {CW'(1), 32'h88})
         $display("FAIL empty_push_pop got c=%0d head=%h expected 1/88", cnt, h_addr);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         int pr;
         pr = (i < 200) ? 80 : 35;
         step(($urandom_range(99) < pr), 1'($urandom), ADDR_W'($urandom),
              {32'($urandom), 32'($urandom)}, ($urandom_range(99) < 50));
         n_chk++;
         if (cnt !== CW'(q.size()) || empty !== (q.size() == 0) || busy !== m_busy ||
             ovf !== m_over || unf !== m_under || perr !== 1'b0 ||
             (q.size() > 0 && {h_rdwr, h_addr, h_data} !== q[0]))
            $display("FAIL random cyc %0d got c=%0d e=%b b=%b o=%b u=%b p=%b expected c=%0d b=%b o=%b u=%b",
                     i, cnt, empty, busy, ovf, unf, perr, q.size(), m_busy, m_over, m_under);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, ADDR_W'(32'hF0 + i), DATA_W'(i + 1), 1'b0);
      #2 reset = 1'b0;
      #1;
      n_chk++; if ({empty, busy, cnt, ovf, unf, perr, h_rdwr, h_addr, h_data} !== {1'b1, 1'b0, CW'(0), 3'b000, 97'b0})
         $display("FAIL reset_mid got e=%b b=%b c=%0d u=%b head %h", empty, busy, cnt, unf, h_addr);
      else n_pass++;
      #1 reset = 1'b1;
      q.delete();
      m_over = 1'b0; m_under = 1'b0; m_busy = 1'b0;
      step(1'b1, 1'b0, 32'hABC, 64'h1, 1'b0);
      n_chk++; if ({cnt, h_addr} !== {CW'(1), 32'hABC})
         $display("FAIL reset_recover got c=%0d head=%h", cnt, h_addr);
      else n_pass++;
   endtask

   initial begin
      m_over = 1'b0; m_under = 1'b0; m_busy = 1'b0;
      #3;
      test_reset();
      test_single();
      test_fill_overflow();
      test_simul();
      test_underflow();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mc_input_req_fifo.md
# mc_input_req_fifo

Request buffer between the system port and the memory-controller decoder. Captures each system request (read/write flag, address, write data) into a fixed-depth FIFO. Presents the oldest entry to the decoder first-word-fall-through, and the decoder pops it with `input_fifo_read`. Drives `mc__sys__dram_busy` early enough that the system can stop issuing before the buffer overflows.

## Interface
Parameters:
- `ADDR_W`, default 32: system request address width.
- `DATA_W`, default 64: system write-data width.
- `DEPTH`, default 8: number of entries; must be a power of 2 and ≥ 4.
- `BUSY_MARGIN`, default 2: free entries still available when busy asserts; must be ≥ 1 and < `DEPTH`.

Ports (`CW` = $clog2(`DEPTH`)+1):
- `clk`, input, 1: single clock; all state is updated on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `sys__mc__dram_req`, input, 1: request valid; push on this edge.
- `sys__mc__dram_rdwr`, input, 1: 1 = read, 0 = write.
- `sys__mc__dram_addr`, input, `ADDR_W`: request address.
- `sys__mc__dram_wr_data`, input, `DATA_W`: write data; stored for reads too.
- `input_fifo_read`, input, 1: decoder pop of the head entry.
- `input_fifo_read_rdwr`, output, 1: head entry rdwr.
- `input_fifo_read_addr`, output, `ADDR_W`: head entry address.
- `input_fifo_read_wr_data`, output, `DATA_W`: head entry write data.
- `input_fifo_empty`, output, 1: no valid head entry.
- `mc__sys__dram_busy`, output, 1: system must stop issuing requests.
- `input_fifo_count`, output, `CW`: current occupancy.
- `input_fifo_overflow`, output, 1: sticky; a request was dropped.
- `input_fifo_underflow`, output, 1: sticky; a pop occurred while empty.
- `input_fifo_parity_err`, output, 1: sticky parity mismatch (see Configuration).

## Operation
- Storage: `DEPTH`-entry register array with write pointer `wp` and read pointer `rp`. Each pointer is `CW-1` bits and wraps from `DEPTH-1` to 0. Occupancy is kept as a separate `CW`-bit counter.
- Push: accepted when `sys__mc__dram_req` = 1 and (count < `DEPTH` or a valid pop occurs in the same cycle). The entry is written at `wp`, and `wp` increments.
- Pop: valid when `input_fifo_read` = 1 and count > 0. `rp` increments.
- Count update: count +1 for a push only, −1 for a pop only, unchanged when both occur.
- Full with push and pop in the same cycle: the push is accepted and count stays at `DEPTH`.
- Full with push and no pop: the request is dropped, `input_fifo_overflow` is set, and pointers and count are unchanged.
- Pop while empty: ignored, `input_fifo_underflow` is set, and pointers are unchanged. If a push occurs in the same cycle it is accepted and count becomes 1.
- Head outputs show `mem[rp]` combinationally. When empty they hold the last popped value and are don't-care.
- `input_fifo_empty` = (count == 0).
- `mc__sys__dram_busy` is a register, loaded each edge with (next_count ≥ `DEPTH` − `BUSY_MARGIN`).
- Sticky flags clear only on reset.

## Timing
- Reset values: pointers 0, count 0, `input_fifo_empty` = 1, `mc__sys__dram_busy` = 0, all sticky flags 0, all array entries and head outputs 0.
- Push-to-visible latency is 1 cycle: a request sampled at edge N appears on the head outputs with `input_fifo_empty` = 0 after edge N.
- A pop at edge N presents the next entry after edge N. Back-to-back pops sustain one entry per cycle.
- `mc__sys__dram_busy` reflects the occupancy after the same edge. The system sees it one cycle later, and `BUSY_MARGIN` ≥ 1 absorbs that in-flight request.
- Reset asserted mid-operation immediately clears all state asynchronously. Any entries in flight are discarded.

## Configuration
- Macro `MC_INFIFO_PARITY_EN`, when defined:
  - Each entry stores one extra bit holding the even parity of {rdwr, addr, wr_data}, computed at push.
  - At each valid pop, the stored parity is compared with parity recomputed from the head outputs; a mismatch sets sticky `input_fifo_parity_err`.
- When undefined: no parity storage or check logic; `input_fifo_parity_err` is tied to 0.

## Test plan
- Reset only -> `input_fifo_empty` = 1, `mc__sys__dram_busy` = 0, `input_fifo_count` = 0, all sticky flags 0, head outputs 0.
- One write request (rdwr = 0, addr 0x0000_1234, data 0xA5A5) at edge N -> after N: empty = 0, count = 1, head = (0, 0x1234, 0xA5A5). Pop at edge N+1 -> after N+1: empty = 1, count = 0.
- 8 requests with no pops (`DEPTH` 8, `BUSY_MARGIN` 2) -> busy asserts after the 6th push. A 9th request -> dropped, `input_fifo_overflow` = 1, count = 8. Then 8 pops -> addresses return in push order and busy deasserts once count ≤ 5.
- Simultaneous push and pop at count 3, then at count 8 -> count stays 3, then stays 8. Overflow stays 0 and ordering is preserved across pointer wrap (more than 16 total transfers).
- Pop on empty -> underflow = 1, count 0, pointers unchanged. The next push appears at the head correctly.
- 5 entries buffered, reset pulsed low mid-cycle -> all outputs return to reset values immediately. With `MC_INFIFO_PARITY_EN` defined and 32 random requests, `input_fifo_parity_err` stays 0.
